// File: rtl/switchbox_cfg_pkg.sv
// rtl/switchbox_cfg_pkg.sv - shared constants, state enum and select-word legality for the switchbox config loader
package switchbox_cfg_pkg;

  localparam logic [2:0] SIDE_NONE   = 3'd0;
  localparam logic [2:0] SIDE_TOP    = 3'd1;
  localparam logic [2:0] SIDE_RIGHT  = 3'd2;
  localparam logic [2:0] SIDE_BOTTOM = 3'd3;
  localparam logic [2:0] SIDE_LEFT   = 3'd4;

  localparam int SIDE_LSB = 0;
  localparam int SIDE_W   = 3;
  localparam int IDX_LSB  = 3;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LOAD,
    ST_CRC,
    ST_CHECK
  } state_e;

  // Index range depends on which side the select points at; codes 5..7 are never legal.
  function automatic logic word_legal(input logic [2:0] side, input int idx,
                                      input int rows, input int cols);
    case (side)
      SIDE_NONE:               word_legal = 1'b1;
      SIDE_TOP, SIDE_BOTTOM:   word_legal = (idx < cols);
      SIDE_RIGHT, SIDE_LEFT:   word_legal = (idx < rows);
      default:                 word_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// rtl/crc8_serial.sv - bit-serial MSB-first CRC-8, no reflection, no final xor
module crc8_serial
  import switchbox_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[7] ^ din;
    if (clr) begin
      crc_d = 8'h00;
    end else if (en) begin
      crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= 8'h00;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/switchbox_cfg_loader.sv
// rtl/switchbox_cfg_loader.sv - serial bitstream loader with sync hunt, CRC-8 and legality check, atomic select commit
module switchbox_cfg_loader
  import switchbox_cfg_pkg::*;
#(
  parameter int         ROWS      = 4,
  parameter int         COLS      = 5,
  parameter int         DW        = 6,
  parameter logic [7:0] SYNC_WORD = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_bit,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               cfg_abort,
  output logic [COLS*DW-1:0] sel_top,
  output logic [COLS*DW-1:0] sel_bottom,
  output logic [ROWS*DW-1:0] sel_left,
  output logic [ROWS*DW-1:0] sel_right,
  output logic               cfg_done,
  output logic               cfg_err,
  output logic               busy
);

  localparam int NWORDS = 2*COLS + 2*ROWS;
  localparam int NBITS  = NWORDS*DW;
  localparam int CW     = $clog2(NBITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(NBITS-1);
  localparam logic [CW-1:0] CRC_LAST = CW'(7);

  state_e             state_q, state_d;
  logic [7:0]         window_q, window_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NBITS-1:0]   shadow_q, shadow_d;
  logic [NBITS-1:0]   active_q, active_d;
  logic [7:0]         crc_rx_q, crc_rx_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               accept, crc_clr, crc_en, all_legal, pass;
  logic [7:0]         crc_calc;

  assign cfg_ready = (state_q != ST_CHECK);
  assign busy      = (state_q != ST_HUNT);
  assign accept    = cfg_valid & cfg_ready;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

  crc8_serial u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (cfg_bit),
    .crc   (crc_calc)
  );

  always_comb begin
    all_legal = 1'b1;
    for (int w = 0; w < NWORDS; w++) begin
      if (!word_legal(shadow_q[w*DW+SIDE_LSB +: SIDE_W],
                      int'(shadow_q[w*DW+IDX_LSB +: DW-IDX_LSB]), ROWS, COLS))
        all_legal = 1'b0;
    end
  end

  assign pass = (crc_rx_q == crc_calc) && all_legal;

  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    crc_rx_d = crc_rx_q;
    active_d = active_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;
    // Abort wins over any bit accepted in the same cycle and over a pending commit.
    if (cfg_abort) begin
      state_d  = ST_HUNT;
      window_d = 8'h00;
      cnt_d    = '0;
      crc_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_HUNT: if (accept) begin
          window_d = {window_q[6:0], cfg_bit};
          if (window_d == SYNC_WORD) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            crc_clr = 1'b1;
          end
        end
        ST_LOAD: if (accept) begin
          // Shifting in from the LSB leaves payload bit k at NBITS-1-k once full.
          shadow_d = {shadow_q[NBITS-2:0], cfg_bit};
          crc_en   = 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_d = ST_CRC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_CRC: if (accept) begin
          crc_rx_d = {crc_rx_q[6:0], cfg_bit};
          if (cnt_q == CRC_LAST) begin
            state_d = ST_CHECK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_CHECK: begin
          if (pass) begin
            active_d = shadow_q;
            done_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d  = ST_HUNT;
          window_d = 8'h00;
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_HUNT;
      window_q <= 8'h00;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      crc_rx_q <= 8'h00;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      crc_rx_q <= crc_rx_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Transmission order is top, bottom, left, right with word 0 of each group first (MSB end).
  for (genvar i = 0; i < COLS; i++) begin : g_cols
    assign sel_top[i*DW +: DW]    = active_q[(NWORDS-1-i)*DW +: DW];
    assign sel_bottom[i*DW +: DW] = active_q[(NWORDS-1-COLS-i)*DW +: DW];
  end
  for (genvar i = 0; i < ROWS; i++) begin : g_rows
    assign sel_left[i*DW +: DW]   = active_q[(NWORDS-1-2*COLS-i)*DW +: DW];
    assign sel_right[i*DW +: DW]  = active_q[(NWORDS-1-2*COLS-ROWS-i)*DW +: DW];
  end

endmodule

// File: tb/tb_switchbox_cfg_loader.sv
// tb/tb_switchbox_cfg_loader.sv - scoreboard bench for switchbox_cfg_loader with a frame-level reference model
module tb_switchbox_cfg_loader;

  localparam int ROWS  = 4;
  localparam int COLS  = 5;
  localparam int DW    = 6;
  localparam int NW    = 2*COLS + 2*ROWS;
  localparam int NBITS = NW*DW;

  logic               clk, rst_n;
  logic               cfg_bit, cfg_valid, cfg_abort;
  logic               cfg_ready, cfg_done, cfg_err, busy;
  logic [COLS*DW-1:0] sel_top, sel_bottom;
  logic [ROWS*DW-1:0] sel_left, sel_right;

  switchbox_cfg_loader #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .SYNC_WORD(8'hA5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_bit    (cfg_bit),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_abort  (cfg_abort),
    .sel_top    (sel_top),
    .sel_bottom (sel_bottom),
    .sel_left   (sel_left),
    .sel_right  (sel_right),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit               is_done;
    logic [NBITS-1:0] sel;
  } exp_t;

  int               errors = 0;
  int               checks = 0;
  int               ready_low;
  logic [DW-1:0]    words [NW];
  logic [NBITS-1:0] model_sel;
  exp_t             exp_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [NBITS-1:0] pack_sel();
    logic [COLS*DW-1:0] t, b;
    logic [ROWS*DW-1:0] l, r;
    for (int i = 0; i < COLS; i++) begin
      t[i*DW +: DW] = words[i];
      b[i*DW +: DW] = words[COLS+i];
    end
    for (int i = 0; i < ROWS; i++) begin
      l[i*DW +: DW] = words[2*COLS+i];
      r[i*DW +: DW] = words[2*COLS+ROWS+i];
    end
    return {t, b, l, r};
  endfunction

  function automatic bit word_ok(input logic [DW-1:0] w);
    int side = int'(w[2:0]);
    int idx  = int'(w[DW-1:3]);
    if (side == 0) return 1'b1;
    if (side == 1 || side == 3) return idx < COLS;
    if (side == 2 || side == 4) return idx < ROWS;
    return 1'b0;
  endfunction

  // Remainder of M(x)*x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_model(input bit msg [$]);
    logic [8:0] rem = 9'h000;
    bit         ext [$];
    ext = msg;
    for (int i = 0; i < 8; i++) ext.push_back(1'b0);
    foreach (ext[i]) begin
      rem = {rem[7:0], ext[i]};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  // Entered and left at posedge+1; waits until the bit is actually taken.
  task automatic send_bit(input logic b, input int gap_pct);
    int  guard = 0;
    bit  took;
    do begin
      cfg_bit   = b;
      cfg_valid = ($urandom_range(99) >= gap_pct);
      if (!cfg_ready) ready_low++;
      took = cfg_valid && cfg_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!took && guard < 1000);
    cfg_valid = 1'b0;
    if (!took) check("send_bit_timeout", 128'(guard), 128'(0));
  endtask

  task automatic send_sync(input int gap_pct);
    logic [7:0] s = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(s[i], gap_pct);
  endtask

  task automatic send_frame(input int flip, input int gap_pct);
    bit         payload [$];
    logic [7:0] crc;
    bit         pass = 1'b1;
    exp_t       e;
    for (int w = 0; w < NW; w++) begin
      for (int j = DW-1; j >= 0; j--) payload.push_back(words[w][j]);
      if (!word_ok(words[w])) pass = 1'b0;
    end
    crc = crc_model(payload);
    if (flip >= 0) begin
      payload[flip] = ~payload[flip];
      pass = 1'b0;
    end
    if (pass) model_sel = pack_sel();
    e.is_done = pass;
    e.sel     = model_sel;
    exp_q.push_back(e);
    ready_low = 0;
    send_sync(gap_pct);
    foreach (payload[i]) send_bit(payload[i], gap_pct);
    for (int i = 7; i >= 0; i--) send_bit(crc[i], gap_pct);
    if (!cfg_ready) ready_low++;
    check("busy_in_check", 128'(busy), 128'(1));
    @(posedge clk);
    #1;
    check("ready_after_check", 128'(cfg_ready), 128'(1));
    check("ready_low_cycles", 128'(ready_low), 128'(1));
  endtask

  task automatic clear_words();
    for (int w = 0; w < NW; w++) words[w] = '0;
  endtask

  task automatic random_words(input bit legal_only);
    int side;
    for (int w = 0; w < NW; w++) begin
      if (legal_only) begin
        side = $urandom_range(4);
        words[w][2:0] = 3'(side);
        if (side == 0)                  words[w][DW-1:3] = 3'($urandom_range(7));
        else if (side == 1 || side == 3) words[w][DW-1:3] = 3'($urandom_range(COLS-1));
        else                            words[w][DW-1:3] = 3'($urandom_range(ROWS-1));
      end else begin
        words[w] = DW'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    logic [10:0] hunt_bits;
    rst_n     = 1'b0;
    cfg_bit   = 1'b0;
    cfg_valid = 1'b0;
    cfg_abort = 1'b0;
    model_sel = '0;
    clear_words();

    fork
      forever begin
        @(negedge clk);
        if (rst_n && (cfg_done || cfg_err)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", 128'({cfg_done, cfg_err}), 128'(0));
          end else begin
            e = exp_q.pop_front();
            check("outcome", 128'({cfg_done, cfg_err}), e.is_done ? 128'(2'b10) : 128'(2'b01));
            check("sel_on_event", 128'({sel_top, sel_bottom, sel_left, sel_right}), 128'(e.sel));
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    check("reset_sel", 128'({sel_top, sel_bottom, sel_left, sel_right}), 128'(0));
    check("reset_done", 128'(cfg_done), 128'(0));
    check("reset_err", 128'(cfg_err), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_ready", 128'(cfg_ready), 128'(1));

    // Reference frame: top[0] -> right[2], left[3] -> top[0].
    clear_words();
    words[0]          = 6'b010_010;
    words[2*COLS + 3] = 6'b000_001;
    send_frame(-1, 0);
    check("valid_top0", 128'(sel_top[5:0]), 128'(6'b010010));
    check("valid_left3", 128'(sel_left[23:18]), 128'(6'b000001));
    check("valid_done_pulse", 128'(cfg_done), 128'(1));

    send_frame(37, 0);
    check("flip_top0_held", 128'(sel_top[5:0]), 128'(6'b010010));

    clear_words();
    words[2*COLS + ROWS] = 6'b101_010;
    send_frame(-1, 0);
    clear_words();
    words[1] = 6'b000_110;
    send_frame(-1, 0);
    clear_words();
    words[COLS + 4] = 6'b100_001;
    send_frame(-1, 0);
    check("bottom4_commit", 128'(sel_bottom[29:24]), 128'(6'b100001));

    // Sync hunt over a noisy prefix, then abort mid-payload.
    hunt_bits = 11'b10110100101;
    for (int i = 10; i >= 1; i--) send_bit(hunt_bits[i], 0);
    check("hunt_not_yet", 128'(busy), 128'(0));
    send_bit(hunt_bits[0], 0);
    check("hunt_enter_load", 128'(busy), 128'(1));
    for (int i = 0; i < 50; i++) send_bit(1'($urandom), 0);
    cfg_abort = 1'b1;
    cfg_bit   = 1'b1;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_sel", 128'({sel_top, sel_bottom, sel_left, sel_right}), 128'(model_sel));
    idle(4);

    clear_words();
    words[0]          = 6'b010_010;
    words[2*COLS + 3] = 6'b000_001;
    send_frame(-1, 30);
    check("gap_top0", 128'(sel_top[5:0]), 128'(6'b010010));

    // Asynchronous reset in the middle of a payload.
    send_sync(0);
    for (int i = 0; i < 30; i++) send_bit(1'($urandom), 0);
    rst_n = 1'b0;
    #1;
    model_sel = '0;
    check("rst_sel", 128'({sel_top, sel_bottom, sel_left, sel_right}), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_ready", 128'(cfg_ready), 128'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    random_words(1'b1);
    send_frame(-1, 0);

    for (int n = 0; n < 8; n++) begin
      random_words($urandom_range(1) == 1);
      send_frame(($urandom_range(3) == 0) ? int'($urandom_range(NBITS-1)) : -1,
                 int'($urandom_range(40)));
    end

    idle(5);
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
